// File: rtl/fetcher.sv
// Per-warp instruction fetch stage.
// A fetch request is issued when the scheduler enters WARP_FETCH. The fetched word is
// held on `instruction` for the decoder.
// Optional direct-mapped instruction cache, enabled by defining FETCH_ICACHE_EN.
package fetcher_pkg;
  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  typedef logic [31:0] instruction_t;
endpackage

module fetcher
  import fetcher_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 32,
  parameter int ICACHE_DEPTH          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  warp_state_t                      warp_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [1:0]                       fetcher_state,
  output instruction_t                     instruction
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FETCHING = 2'b01,
    ST_FETCHED  = 2'b10
  } fetch_state_t;

  fetch_state_t                     state_r, state_s;
  logic                             valid_r, valid_s;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_r, addr_s;
  instruction_t                     instr_r, instr_s;

`ifdef FETCH_ICACHE_EN
  localparam int IDX_BITS = $clog2(ICACHE_DEPTH);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  logic [ICACHE_DEPTH-1:0]          line_valid_r;
  logic [PROGRAM_MEM_DATA_BITS-1:0] line_data_r [ICACHE_DEPTH];
  logic [TAG_BITS-1:0]              line_tag_r  [ICACHE_DEPTH];
  logic [IDX_BITS-1:0]              lookup_idx_s;
  logic [TAG_BITS-1:0]              lookup_tag_s;
  logic [IDX_BITS-1:0]              fill_idx_s;
  logic [TAG_BITS-1:0]              fill_tag_s;
  logic                             hit_s;
  logic                             fill_s;

  // Cache lookup uses the live PC; a fill uses the latched request address.
  always_comb begin
    lookup_idx_s = current_pc[IDX_BITS-1:0];
    lookup_tag_s = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
    fill_idx_s   = addr_r[IDX_BITS-1:0];
    fill_tag_s   = addr_r[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
    hit_s        = line_valid_r[lookup_idx_s] && (line_tag_r[lookup_idx_s] == lookup_tag_s);
  end

  // Valid bits are cleared by reset or flush. They are set when a line is filled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_valid_r <= '0;
    end else if (flush) begin
      line_valid_r <= '0;
    end else if (fill_s) begin
      line_valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Line payload needs no reset because the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      line_data_r[fill_idx_s] <= mem_read_data;
      line_tag_r[fill_idx_s]  <= fill_tag_s;
    end
  end
`endif

  // Next-state and next-output logic. A flush overrides every other transition.
  always_comb begin
    state_s = state_r;
    valid_s = valid_r;
    addr_s  = addr_r;
    instr_s = instr_r;
`ifdef FETCH_ICACHE_EN
    fill_s  = 1'b0;
`endif
    if (flush) begin
      state_s = ST_IDLE;
      valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (warp_state == WARP_FETCH) begin
`ifdef FETCH_ICACHE_EN
            if (hit_s) begin
              instr_s = line_data_r[lookup_idx_s];
              state_s = ST_FETCHED;
            end else begin
              addr_s  = current_pc;
              valid_s = 1'b1;
              state_s = ST_FETCHING;
            end
`else
            addr_s  = current_pc;
            valid_s = 1'b1;
            state_s = ST_FETCHING;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCHING: begin
          if (mem_read_ready) begin
            instr_s = mem_read_data;
            valid_s = 1'b0;
            state_s = ST_FETCHED;
`ifdef FETCH_ICACHE_EN
            fill_s  = 1'b1;
`endif
          end else begin
            state_s = ST_FETCHING;
          end
        end
        ST_FETCHED: begin
          // The decoder samples `instruction` on this same edge, so it is left untouched.
          if (warp_state == WARP_DECODE) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_FETCHED;
          end
        end
        default: begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers. Reset is asynchronous so a request is dropped at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      addr_r  <= '0;
      instr_r <= '0;
    end else begin
      state_r <= state_s;
      valid_r <= valid_s;
      addr_r  <= addr_s;
      instr_r <= instr_s;
    end
  end

  assign fetcher_state    = state_r;
  assign mem_read_valid   = valid_r;
  assign mem_read_address = addr_r;
  assign instruction      = instr_r;

endmodule
